// File: rtl/pong_core.sv
`default_nettype none
// ============================================================================
//  Module   : pong_core
//  Purpose  : Two-player LED pong engine. Serves, moves the ball on divider
//             steps, judges hits, misses and early presses, keeps the scores
//             and a rally count, and ends the game at WIN_SCORE.
//  Revision : 1.0  initial release
// ============================================================================
module pong_core #(
    parameter int N_LED     = 8,
    parameter int SCORE_W   = 4,
    parameter int WIN_SCORE = 9,
    parameter int RALLY_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic               btn_l,
    input  logic               btn_r,
    output logic [N_LED-1:0]   led,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [RALLY_W-1:0] rally,
    output logic               point_l,
    output logic               point_r,
    output logic               game_over,
    output logic               winner
);

    localparam int                 POS_W   = $clog2(N_LED);
    localparam int                 HALF    = N_LED / 2;
    localparam logic [POS_W-1:0]   POS_MAX = POS_W'(N_LED - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_TO_L  = 2'd1,
        ST_TO_R  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic               server_q,    server_d;     // 1 = left serves
    logic [POS_W-1:0]   pos_q,       pos_d;
    logic [SCORE_W-1:0] score_l_q,   score_l_d;
    logic [SCORE_W-1:0] score_r_q,   score_r_d;
    logic [RALLY_W-1:0] rally_q,     rally_d;
    logic [N_LED-1:0]   led_q,       led_d;
    logic               point_l_q,   point_l_d;
    logic               point_r_q,   point_r_d;
    logic               game_over_q, game_over_d;
    logic               winner_q,    winner_d;     // 1 = left won

    logic               pt_l;
    logic               pt_r;
    logic [RALLY_W-1:0] rally_inc;
    logic [HALF+SCORE_W-1:0] score_l_ext;
    logic [HALF+SCORE_W-1:0] score_r_ext;

    // Game rules: serve, ball travel, hit/miss/early judgement, point resolution
    always_comb begin
        state_d   = state_q;
        server_d  = server_q;
        pos_d     = pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        rally_d   = rally_q;
        winner_d  = winner_q;
        pt_l      = 1'b0;
        pt_r      = 1'b0;
        rally_inc = (rally_q == {RALLY_W{1'b1}}) ? rally_q : rally_q + RALLY_W'(1);

        case (state_q)
            ST_SERVE: begin
                if (!server_q && btn_r) begin
                    pos_d   = '0;
                    rally_d = '0;
                    state_d = ST_TO_L;
                end else if (server_q && btn_l) begin
                    pos_d   = POS_MAX;
                    rally_d = '0;
                    state_d = ST_TO_R;
                end
            end
            ST_TO_L: begin
                // A press is judged before the step so a same-cycle hit wins
                if (btn_l) begin
                    if (pos_q == POS_MAX) begin
                        rally_d = rally_inc;
                        state_d = ST_TO_R;
                    end else begin
                        pt_r = 1'b1;
                    end
                end else if (step) begin
                    if (pos_q != POS_MAX) pos_d = pos_q + POS_W'(1);
                    else                  pt_r  = 1'b1;
                end
            end
            ST_TO_R: begin
                if (btn_r) begin
                    if (pos_q == '0) begin
                        rally_d = rally_inc;
                        state_d = ST_TO_L;
                    end else begin
                        pt_l = 1'b1;
                    end
                end else if (step) begin
                    if (pos_q != '0) pos_d = pos_q - POS_W'(1);
                    else             pt_l  = 1'b1;
                end
            end
            ST_OVER: begin
                if (btn_l || btn_r) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    server_d  = ~winner_q;
                    state_d   = ST_SERVE;
                end
            end
            default: state_d = ST_SERVE;
        endcase

        // Points resolve in the same cycle; the loser serves next
        if (pt_r) begin
            score_r_d = score_r_q + SCORE_W'(1);
            if (score_r_d == WIN_VAL) begin
                state_d  = ST_OVER;
                winner_d = 1'b0;
            end else begin
                state_d  = ST_SERVE;
                server_d = 1'b1;
            end
        end
        if (pt_l) begin
            score_l_d = score_l_q + SCORE_W'(1);
            if (score_l_d == WIN_VAL) begin
                state_d  = ST_OVER;
                winner_d = 1'b1;
            end else begin
                state_d  = ST_SERVE;
                server_d = 1'b0;
            end
        end

        point_l_d   = pt_l;
        point_r_d   = pt_r;
        game_over_d = (state_d == ST_OVER);
    end

    // LED image for the upcoming state so the registered bar matches it
    always_comb begin
        score_l_ext = {{HALF{1'b0}}, score_l_d};
        score_r_ext = {{HALF{1'b0}}, score_r_d};
        led_d       = '0;
        case (state_d)
            ST_SERVE: led_d = {score_l_ext[HALF-1:0], score_r_ext[HALF-1:0]};
            ST_TO_L,
            ST_TO_R:  led_d[pos_d] = 1'b1;
            ST_OVER:  led_d = winner_d ? {{HALF{1'b1}}, {HALF{1'b0}}}
                                       : {{HALF{1'b0}}, {HALF{1'b1}}};
            default:  led_d = '0;
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SERVE;
            server_q    <= 1'b0;
            pos_q       <= '0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            rally_q     <= '0;
            led_q       <= '0;
            point_l_q   <= 1'b0;
            point_r_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            server_q    <= server_d;
            pos_q       <= pos_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            rally_q     <= rally_d;
            led_q       <= led_d;
            point_l_q   <= point_l_d;
            point_r_q   <= point_r_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign led       = led_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign rally     = rally_q;
    assign point_l   = point_l_q;
    assign point_r   = point_r_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pong_core
//  Purpose  : Directed scoreboard bench for pong_core (N_LED=8, WIN_SCORE=3).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pong_core;

    typedef struct packed {
        logic [7:0] led;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [3:0] ra;
        logic       pl;
        logic       pr;
        logic       go;
        logic       win;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       step;
    logic       btn_l;
    logic       btn_r;
    logic [7:0] led;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [3:0] rally;
    logic       point_l;
    logic       point_r;
    logic       game_over;
    logic       winner;

    exp_t  sb[$];
    string tg[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    pong_core #(
        .N_LED    (8),
        .SCORE_W  (4),
        .WIN_SCORE(3),
        .RALLY_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .btn_l    (btn_l),
        .btn_r    (btn_r),
        .led      (led),
        .score_l  (score_l),
        .score_r  (score_r),
        .rally    (rally),
        .point_l  (point_l),
        .point_r  (point_r),
        .game_over(game_over),
        .winner   (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input logic [7:0] l, input logic [3:0] sl, input logic [3:0] sr,
                                input logic [3:0] ra, input logic pl, input logic pr,
                                input logic go, input logic w);
        mk = {l, sl, sr, ra, pl, pr, go, w};
    endfunction

    task automatic compare();
        exp_t  e;
        exp_t  o;
        string t;
        e = sb.pop_front();
        t = tg.pop_front();
        o = {led, score_l, score_r, rally, point_l, point_r, game_over, winner};
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (led,sl,sr,rally,pl,pr,go,win)", t, o, e);
        end
    endtask

    // One clock with the given one-cycle inputs, then check the registered result
    task automatic cyc(input logic bl, input logic br, input logic st, input exp_t e, input string tag);
        btn_l = bl;
        btn_r = br;
        step  = st;
        sb.push_back(e);
        tg.push_back(tag);
        @(posedge clk);
        #1;
        btn_l = 1'b0;
        btn_r = 1'b0;
        step  = 1'b0;
        compare();
    endtask

    initial begin
        logic [7:0] v;
        rst   = 1'b0;
        step  = 1'b0;
        btn_l = 1'b0;
        btn_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tg.push_back("reset");
        compare();
        rst = 1'b1;

        // Serve from the right; left button and step ignored while serving
        cyc(1'b0, 1'b0, 1'b1, mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "serve_step_ign");
        cyc(1'b1, 1'b0, 1'b0, mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "serve_btn_l_ign");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "serve_r");
        for (int i = 1; i < 8; i++) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_l_step");
        end
        cyc(1'b0, 1'b1, 1'b0, mk(8'h80, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_l_btn_r_ign");

        // Left hit, travel right, right hit
        cyc(1'b1, 1'b0, 1'b0, mk(8'h80, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "hit_l");
        for (int i = 6; i >= 0; i--) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "to_r_step");
        end
        cyc(1'b1, 1'b0, 1'b0, mk(8'h01, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "to_r_btn_l_ign");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "hit_r");
        for (int i = 1; i < 8; i++) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "to_l_step2");
        end

        // Left misses: right scores, left serves next
        cyc(1'b0, 1'b0, 1'b1, mk(8'h01, 4'd0, 4'd1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0), "miss_l");
        cyc(1'b0, 1'b0, 1'b0, mk(8'h01, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "point_pulse_end");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "serve_l_btn_r_ign");
        cyc(1'b1, 1'b0, 1'b0, mk(8'h80, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "serve_l");
        for (int i = 6; i >= 0; i--) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_r_step2");
        end
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "hit_r2");
        for (int i = 1; i < 5; i++) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "to_l_step3");
        end

        // Early left press at 0x10: right scores
        cyc(1'b1, 1'b0, 1'b0, mk(8'h02, 4'd0, 4'd2, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0), "early_l");
        cyc(1'b1, 1'b0, 1'b0, mk(8'h80, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "serve_l2");
        for (int i = 6; i >= 0; i--) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_r_step3");
        end
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "hit_r3");
        for (int i = 1; i < 8; i++) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "to_l_step4");
        end

        // Same-cycle step and press at the end is a hit
        cyc(1'b1, 1'b0, 1'b1, mk(8'h80, 4'd0, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "step_and_hit");
        cyc(1'b0, 1'b0, 1'b1, mk(8'h40, 4'd0, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0), "after_hit");

        // Early right press: left scores, right serves next
        cyc(1'b0, 1'b1, 1'b0, mk(8'h12, 4'd1, 4'd2, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0), "early_r");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "serve_r2");

        // Right reaches WIN_SCORE
        cyc(1'b1, 1'b0, 1'b0, mk(8'h0F, 4'd1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0), "win_r");
        cyc(1'b0, 1'b0, 1'b1, mk(8'h0F, 4'd1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0), "over_step_ign");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "over_exit");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "loser_serves_btn_r_ign");
        cyc(1'b1, 1'b0, 1'b0, mk(8'h80, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "loser_serves");
        for (int i = 6; i >= 0; i--) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "to_r_step4");
        end
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "hit_r4");
        for (int i = 1; i < 4; i++) begin
            v = 8'd1 << i;
            cyc(1'b0, 1'b0, 1'b1, mk(v, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0), "to_l_step5");
        end

        // Asynchronous reset mid-rally, between clock edges
        #2;
        rst = 1'b0;
        #1;
        sb.push_back(mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tg.push_back("async_reset");
        compare();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, mk(8'h00, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "post_rst_btn_l_ign");
        cyc(1'b0, 1'b1, 1'b0, mk(8'h01, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0), "post_rst_serve_r");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
